// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dmem_arbiter_if                                                  |
// | Brief   : Requester-port and data-memory bus bundle for dmem_arbiter.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              mem_writeEn;
  logic              mem_readEn;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_WriteData;
  logic [DATA_W-1:0] mem_ReadData;

  // Arbiter side: sees requests and memory read data, drives everything else.
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_ReadData,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, busy,
           mem_writeEn, mem_readEn, mem_address, mem_WriteData
  );

  // Requesters plus memory side.
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_ReadData,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy,
           mem_writeEn, mem_readEn, mem_address, mem_WriteData
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dmem_arbiter                                                     |
// | Brief   : Two-port fixed-priority data-memory arbiter with ACCESS/RESP     |
// |           pipeline and port-1 starvation guard.                            |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  dmem_arbiter_if.slave bus
);

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  logic [3:0]        r_starve_cnt;
  logic              w_force1;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_accept;

  logic              r_acc_v;
  logic              r_acc_we;
  logic              r_acc_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              r_resp_v;
  logic              r_resp_owner;
  logic [DATA_W-1:0] r_rdata;

  // Grants are purely request-driven; the pipeline never stalls acceptance.
  always_comb begin
    w_force1 = (r_starve_cnt == c_starve_limit);
    w_gnt1   = ~rst & bus.req1 & (~bus.req0 | w_force1);
    w_gnt0   = ~rst & bus.req0 & ~w_gnt1;
    w_accept = w_gnt0 | w_gnt1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
    end else if (bus.req1 & ~w_gnt1) begin
      if (r_starve_cnt != c_starve_limit) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end else begin
      r_starve_cnt <= 4'd0;
    end
  end

  // ACCESS stage: address/data hold their last value when no new accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_v     <= 1'b0;
      r_acc_we    <= 1'b0;
      r_acc_owner <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_acc_v <= w_accept;
      if (w_accept) begin
        r_acc_owner <= w_gnt1;
        r_acc_we    <= w_gnt1 ? bus.we1    : bus.we0;
        r_addr      <= w_gnt1 ? bus.addr1  : bus.addr0;
        r_wdata     <= w_gnt1 ? bus.wdata1 : bus.wdata0;
      end
    end
  end

  // RESP stage: only reads produce a response; rdata holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_v     <= 1'b0;
      r_resp_owner <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_resp_v     <= r_acc_v & ~r_acc_we;
      r_resp_owner <= r_acc_owner;
      if (r_acc_v & ~r_acc_we) begin
        r_rdata <= bus.mem_ReadData;
      end
    end
  end

  assign bus.gnt0          = w_gnt0;
  assign bus.gnt1          = w_gnt1;
  assign bus.rvalid0       = r_resp_v & ~r_resp_owner;
  assign bus.rvalid1       = r_resp_v &  r_resp_owner;
  assign bus.rdata         = r_rdata;
  assign bus.busy          = r_acc_v | r_resp_v;
  assign bus.mem_writeEn   = r_acc_v &  r_acc_we;
  assign bus.mem_readEn    = r_acc_v & ~r_acc_we;
  assign bus.mem_address   = r_addr;
  assign bus.mem_WriteData = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_dmem_arbiter                                                  |
// | Brief   : Directed self-checking bench for dmem_arbiter with memory model. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic        preload_en;
  logic [7:0]  preload_idx;
  logic [31:0] preload_data;
  logic [31:0] mem [0:255];

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed memory: combinational read, write on the falling edge.
  assign bus.mem_ReadData = bus.mem_readEn ? mem[bus.mem_address[9:2]] : 32'h0;
  always @(negedge clk) begin
    if (preload_en) mem[preload_idx] <= preload_data;
    else if (bus.mem_writeEn) mem[bus.mem_address[9:2]] <= bus.mem_WriteData;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    preload_en   = 1'b1;
    preload_idx  = idx;
    preload_data = data;
    tick();
    preload_en   = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    preload_en = 1'b0; preload_idx = 8'h0; preload_data = 32'h0;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 32'h0; bus.wdata0 = 32'h0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 32'h0; bus.wdata1 = 32'h0;
    rst = 1'b1;

    // Reset state, grants forced low even with requests present
    tick();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    #1;
    chk("rst_gnt0", {31'h0, bus.gnt0}, 32'h0);
    chk("rst_gnt1", {31'h0, bus.gnt1}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_addr", bus.mem_address, 32'h0);
    chk("rst_wdata", bus.mem_WriteData, 32'h0);
    chk("rst_en", {30'h0, bus.mem_writeEn, bus.mem_readEn}, 32'h0);
    bus.req0 = 1'b0; bus.req1 = 1'b0;

    preload(8'h04, 32'hDEADBEEF);
    for (int i = 0; i < 8; i++) preload(8'(8'h40 + i), 32'hA0000000 + 32'(i));
    rst = 1'b0;
    tick();

    // Single port-0 read
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h10;
    #1;
    chk("rd_gnt0", {31'h0, bus.gnt0}, 32'h1);
    chk("rd_gnt1", {31'h0, bus.gnt1}, 32'h0);
    tick();
    bus.req0 = 1'b0;
    #1;
    chk("rd_readEn", {31'h0, bus.mem_readEn}, 32'h1);
    chk("rd_writeEn", {31'h0, bus.mem_writeEn}, 32'h0);
    chk("rd_addr", bus.mem_address, 32'h10);
    chk("rd_busy", {31'h0, bus.busy}, 32'h1);
    chk("rd_early_rvalid", {30'h0, bus.rvalid1, bus.rvalid0}, 32'h0);
    tick(); #1;
    chk("rd_rvalid", {30'h0, bus.rvalid1, bus.rvalid0}, 32'h1);
    chk("rd_rdata", bus.rdata, 32'hDEADBEEF);
    tick(); #1;
    chk("rd_pulse_end", {30'h0, bus.rvalid1, bus.rvalid0}, 32'h0);
    chk("rd_idle_busy", {31'h0, bus.busy}, 32'h0);
    chk("rd_rdata_hold", bus.rdata, 32'hDEADBEEF);

    // Port-1 write then read of same address on the next cycle
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h20; bus.wdata1 = 32'h12345678;
    #1;
    chk("wr_gnt1", {31'h0, bus.gnt1}, 32'h1);
    tick();
    bus.we1 = 1'b0;
    #1;
    chk("wr_gnt1_rd", {31'h0, bus.gnt1}, 32'h1);
    chk("wr_writeEn", {31'h0, bus.mem_writeEn}, 32'h1);
    chk("wr_data", bus.mem_WriteData, 32'h12345678);
    chk("wr_addr", bus.mem_address, 32'h20);
    tick();
    bus.req1 = 1'b0;
    #1;
    chk("wr_no_resp", {30'h0, bus.rvalid1, bus.rvalid0}, 32'h0);
    chk("war_readEn", {31'h0, bus.mem_readEn}, 32'h1);
    tick(); #1;
    chk("war_rvalid", {30'h0, bus.rvalid1, bus.rvalid0}, 32'h2);
    chk("war_rdata", bus.rdata, 32'h12345678);
    tick(); #1;
    chk("war_pulse_end", {30'h0, bus.rvalid1, bus.rvalid0}, 32'h0);

    // Contention: both held high gives 0,0,0,0,1 grant pattern
    bus.req0 = 1'b1; bus.addr0 = 32'h10;
    bus.req1 = 1'b1; bus.addr1 = 32'h20;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("cont_gnt_%0d", i), {30'h0, bus.gnt1, bus.gnt0},
          (i % 5 == 4) ? 32'h2 : 32'h1);
      tick();
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick(); tick(); #1;
    chk("cont_drain", {31'h0, bus.busy}, 32'h0);

    // Simultaneous single requests: port 0 first, port 1 next cycle
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    #1;
    chk("sim_gnt_a", {30'h0, bus.gnt1, bus.gnt0}, 32'h1);
    tick();
    bus.req0 = 1'b0;
    #1;
    chk("sim_gnt_b", {30'h0, bus.gnt1, bus.gnt0}, 32'h2);
    tick();
    bus.req1 = 1'b0;
    #1;
    chk("sim_resp0", {30'h0, bus.rvalid1, bus.rvalid0}, 32'h1);
    chk("sim_rdata0", bus.rdata, 32'hDEADBEEF);
    tick(); #1;
    chk("sim_resp1", {30'h0, bus.rvalid1, bus.rvalid0}, 32'h2);
    chk("sim_rdata1", bus.rdata, 32'h12345678);
    tick();

    // Back-to-back: 8 port-0 reads
    bus.req0 = 1'b1; bus.we0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.addr0 = 32'h100 + 32'(4 * i);
      #1;
      chk($sformatf("b2b_gnt_%0d", i), {31'h0, bus.gnt0}, 32'h1);
      if (i >= 1) chk($sformatf("b2b_busy_%0d", i), {31'h0, bus.busy}, 32'h1);
      if (i >= 2) begin
        chk($sformatf("b2b_rv_%0d", i), {30'h0, bus.rvalid1, bus.rvalid0}, 32'h1);
        chk($sformatf("b2b_rd_%0d", i), bus.rdata, 32'hA0000000 + 32'(i - 2));
      end
      tick();
    end
    bus.req0 = 1'b0;
    #1;
    chk("b2b_rv_6", {30'h0, bus.rvalid1, bus.rvalid0}, 32'h1);
    chk("b2b_rd_6", bus.rdata, 32'hA0000006);
    chk("b2b_busy_t1", {31'h0, bus.busy}, 32'h1);
    tick(); #1;
    chk("b2b_rv_7", {30'h0, bus.rvalid1, bus.rvalid0}, 32'h1);
    chk("b2b_rd_7", bus.rdata, 32'hA0000007);
    chk("b2b_busy_t2", {31'h0, bus.busy}, 32'h1);
    tick(); #1;
    chk("b2b_busy_end", {31'h0, bus.busy}, 32'h0);
    chk("b2b_rv_end", {30'h0, bus.rvalid1, bus.rvalid0}, 32'h0);

    // Reset mid-read: everything drops at once, no response follows
    bus.req0 = 1'b1; bus.addr0 = 32'h10;
    tick();
    #1;
    chk("mr_access", {31'h0, bus.mem_readEn}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mr_gnt0", {31'h0, bus.gnt0}, 32'h0);
    chk("mr_readEn", {31'h0, bus.mem_readEn}, 32'h0);
    chk("mr_addr", bus.mem_address, 32'h0);
    chk("mr_busy", {31'h0, bus.busy}, 32'h0);
    chk("mr_rdata", bus.rdata, 32'h0);
    tick(); #1;
    chk("mr_no_rvalid", {30'h0, bus.rvalid1, bus.rvalid0}, 32'h0);
    bus.req0 = 1'b0;
    rst = 1'b0;
    tick();

    // Reset between accept and memory write: the write is dropped
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h10; bus.wdata0 = 32'hBAD0BAD0;
    tick();
    bus.req0 = 1'b0; bus.we0 = 1'b0;
    rst = 1'b1;
    #1;
    chk("mw_writeEn", {31'h0, bus.mem_writeEn}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    bus.req0 = 1'b1;
    tick();
    bus.req0 = 1'b0;
    tick(); #1;
    chk("mw_rvalid", {30'h0, bus.rvalid1, bus.rvalid0}, 32'h1);
    chk("mw_data_kept", bus.rdata, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
